fifo_rd_packer: RTL and testbench

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_rd_packer.sv | 123 ++++++++++++
 tb/tb_fifo_rd_packer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Pops bytes from a FIFO read port and packs them little-endian into 32-bit words.
// A word is presented when four bytes are captured, or early on flush / idle timeout.
module fifo_rd_packer #(
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        buf_emp,
  input  logic [7:0]  buf_out,
  output logic        re_en,
  input  logic        flush,
  output logic [31:0] word_out,
  output logic [2:0]  byte_cnt,
  output logic        word_vld,
  input  logic        word_rdy
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  lanes_q, lanes_d;
  logic        rd_pend_q;
  logic        flush_req_q, flush_req_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        vld_q, vld_d;
  logic [3:0]  inflight;

  // Bytes already captured plus the one still returning from the FIFO.
  assign inflight = {1'b0, lanes_q} + {3'b000, rd_pend_q};

  always_comb begin
    state_d     = state_q;
    lanes_d     = lanes_q;
    flush_req_d = flush_req_q;
    tmo_d       = tmo_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    vld_d       = vld_q;
    re_en       = 1'b0;

    case (state_q)
      FILL: begin
        re_en = !rst && !buf_emp && !flush_req_q && (inflight < 4'd4);

        if (rd_pend_q) begin
          word_d[{lanes_q[1:0], 3'b000} +: 8] = buf_out;
          lanes_d = lanes_q + 3'd1;
        end

        if (flush) flush_req_d = 1'b1;

        if (rd_pend_q || lanes_q == 3'd0) begin
          tmo_d = 8'd0;
        end else if (buf_emp) begin
          tmo_d = tmo_q + 8'd1;
        end
        if (lanes_q != 3'd0 && tmo_q == TMO_LAST) flush_req_d = 1'b1;

        // A pending flush waits for the in-flight byte so nothing is lost.
        if (rd_pend_q && lanes_q == 3'd3) begin
          state_d = HOLD;
          cnt_d   = 3'd4;
          vld_d   = 1'b1;
          tmo_d   = 8'd0;
        end else if (flush_req_q && !rd_pend_q) begin
          if (lanes_q != 3'd0) begin
            state_d = HOLD;
            cnt_d   = lanes_q;
            vld_d   = 1'b1;
            tmo_d   = 8'd0;
          end else begin
            flush_req_d = 1'b0;
          end
        end
      end

      HOLD: begin
        if (word_rdy) begin
          state_d     = FILL;
          lanes_d     = 3'd0;
          flush_req_d = 1'b0;
          tmo_d       = 8'd0;
          word_d      = 32'd0;
          cnt_d       = 3'd0;
          vld_d       = 1'b0;
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      lanes_q     <= 3'd0;
      rd_pend_q   <= 1'b0;
      flush_req_q <= 1'b0;
      tmo_q       <= 8'd0;
      word_q      <= 32'd0;
      cnt_q       <= 3'd0;
      vld_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lanes_q     <= lanes_d;
      rd_pend_q   <= re_en;
      flush_req_q <= flush_req_d;
      tmo_q       <= tmo_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      vld_q       <= vld_d;
    end
  end

  assign word_out = word_q;
  assign byte_cnt = cnt_q;
  assign word_vld = vld_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-based FIFO feeds the DUT and a byte-stream
// scoreboard checks every presented word, plus directed cases with literal values.
module tb_fifo_rd_packer;

  localparam int TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        buf_emp;
  logic [7:0]  buf_out;
  logic        re_en;
  logic        flush;
  logic [31:0] word_out;
  logic [2:0]  byte_cnt;
  logic        word_vld;
  logic        word_rdy;

  always #5 clk = ~clk;

  fifo_rd_packer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .buf_emp(buf_emp), .buf_out(buf_out), .re_en(re_en),
    .flush(flush), .word_out(word_out), .byte_cnt(byte_cnt), .word_vld(word_vld),
    .word_rdy(word_rdy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] popped[$];
  int         consumed = 0;

  logic        s_re, s_vld, s_emp;
  logic [31:0] s_word;
  logic [2:0]  s_cnt;
  logic        prev_hold = 1'b0, prev_xfer = 1'b0, prev_rst = 1'b0;
  logic [31:0] prev_word = '0;
  logic [2:0]  prev_cnt = '0;
  logic        flush_seen = 1'b0;
  int          empty_run = 0, empty_max = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    buf_emp = 1'b0;
  endtask

  task automatic set_rst(input logic r);
    rst = r;
    if (r) begin
      consumed   = popped.size();
      flush_seen = 1'b0;
      empty_run  = 0;
      empty_max  = 0;
    end
  endtask

  // Per-cycle compare against the byte-stream model; returns whether a pop happens.
  task automatic sample_and_check(output logic pop);
    int avail, cnt;
    logic [31:0] exp;
    s_re = re_en; s_vld = word_vld; s_emp = buf_emp; s_word = word_out; s_cnt = byte_cnt;

    if (rst) check("re_en_in_reset", 32'(re_en), 32'd0);
    if (prev_rst) begin
      check("reset_vld", 32'(word_vld), 32'd0);
      check("reset_cnt", 32'(byte_cnt), 32'd0);
      check("reset_word", word_out, 32'd0);
    end
    if (!word_vld) check("cnt_when_idle", 32'(byte_cnt), 32'd0);
    if (word_vld)  check("re_en_in_hold", 32'(re_en), 32'd0);
    if (re_en)     check("re_en_needs_data", 32'(buf_emp), 32'd0);
    if (prev_hold && !prev_rst) begin
      check("hold_vld", 32'(word_vld), 32'd1);
      check("hold_word", word_out, prev_word);
      check("hold_cnt", 32'(byte_cnt), 32'(prev_cnt));
    end
    if (prev_xfer && !prev_rst) begin
      check("post_xfer_vld", 32'(word_vld), 32'd0);
      check("post_xfer_cnt", 32'(byte_cnt), 32'd0);
      check("post_xfer_word", word_out, 32'd0);
    end
    check("outstanding_le4", 32'((popped.size() - consumed) <= 4), 32'd1);

    if (!word_vld) begin
      if (flush) flush_seen = 1'b1;
      if (buf_emp) begin
        empty_run++;
        if (empty_run > empty_max) empty_max = empty_run;
      end else begin
        empty_run = 0;
      end
    end

    if (word_vld && word_rdy && !rst) begin
      cnt   = int'(byte_cnt);
      avail = popped.size() - consumed;
      check("cnt_range", 32'(cnt >= 1 && cnt <= 4), 32'd1);
      check("bytes_available", 32'(avail >= cnt), 32'd1);
      exp = '0;
      for (int i = 0; i < 4; i++)
        if (i < cnt && i < avail) exp[i*8 +: 8] = popped[consumed + i];
      check("word_content", word_out, exp);
      if (cnt < 4) check("short_word_cause", 32'(flush_seen || empty_max >= TIMEOUT - 1), 32'd1);
      consumed  += (cnt < avail) ? cnt : avail;
      flush_seen = 1'b0;
      empty_run  = 0;
      empty_max  = 0;
    end

    pop       = re_en && !buf_emp;
    prev_hold = word_vld && !word_rdy && !rst;
    prev_xfer = word_vld && word_rdy && !rst;
    prev_word = word_out;
    prev_cnt  = byte_cnt;
    prev_rst  = rst;
  endtask

  task automatic tick();
    logic pop;
    @(negedge clk);
    sample_and_check(pop);
    @(posedge clk);
    #1;
    if (pop && fifo_q.size() > 0) begin
      buf_out = fifo_q.pop_front();
      popped.push_back(buf_out);
    end else begin
      buf_out = 8'($urandom);
    end
    buf_emp = (fifo_q.size() == 0);
  endtask

  task automatic do_reset();
    set_rst(1'b1);
    tick();
    set_rst(1'b0);
  endtask

  task automatic drain(input string name);
    logic done = 1'b0;
    word_rdy = 1'b1;
    flush    = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      done = (fifo_q.size() == 0) && (popped.size() == consumed) && !s_vld && !word_vld;
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, emp, n;
    logic found;
    int pct[6] = '{80, 30, 5, 60, 2, 95};

    rst = 1'b1; buf_emp = 1'b1; buf_out = 8'h00; flush = 1'b0; word_rdy = 1'b0;
    do_reset();
    do_reset();

    // Four bytes, downstream ready: back-to-back pops, one full word.
    word_rdy = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    rc = 0;
    for (int i = 0; i < 4; i++) begin tick(); rc += int'(s_re); end
    check("A_re_burst", 32'(rc), 32'd4);
    tick();
    check("A_vld_before", 32'(s_vld), 32'd0);
    tick();
    check("A_vld", 32'(s_vld), 32'd1);
    check("A_word", s_word, 32'h44332211);
    check("A_cnt", 32'(s_cnt), 32'd4);
    tick();
    check("A_vld_after", 32'(s_vld), 32'd0);
    drain("A_drain");

    // Same data, downstream stalls for 10 cycles while more data waits.
    word_rdy = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int i = 0; i < 5; i++) tick();
    push(8'h99); push(8'hAA); push(8'hBB); push(8'hCC);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("B_hold_vld", 32'(s_vld), 32'd1);
      check("B_hold_word", s_word, 32'h44332211);
      check("B_hold_re", 32'(s_re), 32'd0);
    end
    word_rdy = 1'b1;
    tick();
    check("B_xfer_vld", 32'(s_vld), 32'd1);
    tick();
    check("B_after_vld", 32'(s_vld), 32'd0);
    check("B_turnaround_re", 32'(s_re), 32'd1);
    drain("B_drain");

    // Two bytes then a one-cycle flush.
    word_rdy = 1'b0;
    push(8'hAA); push(8'hBB);
    for (int i = 0; i < 3; i++) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin tick(); found = s_vld; end
    check("C_vld", 32'(found), 32'd1);
    check("C_word", s_word, 32'h0000BBAA);
    check("C_cnt", 32'(s_cnt), 32'd2);
    drain("C_drain");

    // Three bytes then an empty FIFO: timeout flush.
    word_rdy = 1'b0;
    push(8'h01); push(8'h02); push(8'h03);
    emp = 0; found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      found = s_vld;
      if (!found && s_emp) emp++;
    end
    check("D_vld", 32'(found), 32'd1);
    check("D_latency_ok", 32'(emp >= TIMEOUT && emp <= TIMEOUT + 3), 32'd1);
    check("D_word", s_word, 32'h00030201);
    check("D_cnt", 32'(s_cnt), 32'd3);
    drain("D_drain");

    // Flush with nothing captured: no word, request gone one cycle later.
    word_rdy = 1'b1;
    flush = 1'b1; tick(); flush = 1'b0;
    push(8'h5A);
    tick();
    check("E_re_blocked", 32'(s_re), 32'd0);
    check("E_vld0", 32'(s_vld), 32'd0);
    tick();
    check("E_re_resumes", 32'(s_re), 32'd1);
    check("E_vld1", 32'(s_vld), 32'd0);
    drain("E_drain");

    // Reset mid-word with a byte in flight.
    push(8'hE1); push(8'hE2); push(8'hE3);
    for (int i = 0; i < 3; i++) tick();
    do_reset();
    tick();
    check("F_rst_vld", 32'(s_vld), 32'd0);
    check("F_rst_word", s_word, 32'd0);
    check("F_rst_cnt", 32'(s_cnt), 32'd0);
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    found = 1'b0; n = 0;
    for (int i = 0; i < 10 && !found; i++) begin tick(); found = s_vld; n++; end
    check("F_vld", 32'(found), 32'd1);
    check("F_word", s_word, 32'h88776655);
    check("F_cnt", 32'(s_cnt), 32'd4);
    drain("F_drain");

    // Randomized traffic in phases of differing FIFO fill rate.
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 500; c++) begin
        if (fifo_q.size() < 16 && $urandom_range(0, 99) < pct[ph]) push(8'($urandom));
        flush    = ($urandom_range(0, 99) < 3);
        word_rdy = ($urandom_range(0, 99) < 60);
        set_rst($urandom_range(0, 999) == 0);
        tick();
      end
    end
    set_rst(1'b0);
    drain("R_drain");
    check("R_all_consumed", 32'(popped.size() == consumed && fifo_q.size() == 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
